// File: rtl/pe_weight_loader_pkg.sv
// Shared parameters for the PE weight loader.
// These values mirror the codebase-wide parameters.v so the loader
// matches the PE core datapath widths.
package pe_weight_loader_pkg;

    localparam int WEIGHT_WIDTH    = 16;
    localparam int FEATURE_WIDTH   = 16;
    localparam int PE_NUM_PRE_CORE = 3;
    localparam int KERNEL_SIZE     = PE_NUM_PRE_CORE * PE_NUM_PRE_CORE;
    localparam int BIAS_WIDTH      = WEIGHT_WIDTH + FEATURE_WIDTH;
    localparam int CORE_NUM        = 8;

    // Width of a counter or index that must hold values 0..n-1; never 0 bits.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pe_weight_loader.sv
// pe_weight_loader: streams kernel weights (and optionally a bias) from the
// weight buffer into up to CORE_NUM 3x3 PE cores through their shift-in port.
// Each core takes KERNEL_SIZE weights, w0 first, followed by one bias word.
// Optional feature macro: PE_WEIGHT_LOADER_BIAS_EN
//   defined     -> BIAS state present, 10 words per core
//   not defined -> weights only, 9 words per core, bias outputs tied to 0
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start; core count latched here
// WEIGHT | accepting KERNEL_SIZE weight words for core core_idx
// BIAS   | accepting the bias word for core core_idx (BIAS_EN only)
// DONE   | load finished; done pulse follows, then back to IDLE
module pe_weight_loader
    import pe_weight_loader_pkg::*;
(
    input  logic                         DSP_clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [$clog2(CORE_NUM+1)-1:0] core_count,
    input  logic [BIAS_WIDTH-1:0]        s_data,
    input  logic                         s_valid,
    output logic                         s_ready,
    output logic [WEIGHT_WIDTH-1:0]      weight,
    output logic [CORE_NUM-1:0]          weight_valid,
    output logic [BIAS_WIDTH-1:0]        bias,
    output logic [CORE_NUM-1:0]          bias_valid,
    output logic                         busy,
    output logic                         done
);

    localparam int CNT_W  = $clog2(CORE_NUM + 1);
    localparam int IDX_W  = idx_width(CORE_NUM);
    localparam int WCNT_W = idx_width(KERNEL_SIZE);

`ifdef PE_WEIGHT_LOADER_BIAS_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WEIGHT = 2'd1,
        ST_BIAS   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WEIGHT = 2'd1,
        ST_DONE   = 2'd3
    } state_t;
`endif

    state_t              state;
    state_t              state_nx;
    logic [CNT_W-1:0]    count_q;
    logic [CNT_W-1:0]    start_count;
    logic [IDX_W-1:0]    core_idx;
    logic [WCNT_W-1:0]   word_cnt;
    logic [CORE_NUM-1:0] core_onehot;
    logic                hs;
    logic                last_word;
    logic                last_core;

    // Requests beyond the array size load every core instead of wrapping.
    assign start_count = (core_count > CNT_W'(CORE_NUM)) ? CNT_W'(CORE_NUM) : core_count;
    assign last_word   = (word_cnt == WCNT_W'(KERNEL_SIZE - 1));
    assign last_core   = (CNT_W'(core_idx) == (count_q - CNT_W'(1)));
    assign core_onehot = CORE_NUM'(1) << core_idx;

    // State register.
    always_ff @(posedge DSP_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nx = (start_count == '0) ? ST_DONE : ST_WEIGHT;
                end
            end
            ST_WEIGHT: begin
                if (hs && last_word) begin
`ifdef PE_WEIGHT_LOADER_BIAS_EN
                    state_nx = ST_BIAS;
`else
                    if (last_core) begin
                        state_nx = ST_DONE;
                    end
`endif
                end
            end
`ifdef PE_WEIGHT_LOADER_BIAS_EN
            ST_BIAS: begin
                if (hs) begin
                    state_nx = last_core ? ST_DONE : ST_WEIGHT;
                end
            end
`endif
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Stream-side outputs: ready is a pure state decode, no registered stage.
    always_comb begin
        s_ready = 1'b0;
        case (state)
            ST_WEIGHT: s_ready = 1'b1;
`ifdef PE_WEIGHT_LOADER_BIAS_EN
            ST_BIAS:   s_ready = 1'b1;
`endif
            default:   s_ready = 1'b0;
        endcase
        hs = s_valid & s_ready;
    end

    // Counters and registered core-side outputs; weight/bias hold between emits.
    always_ff @(posedge DSP_clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q      <= '0;
            core_idx     <= '0;
            word_cnt     <= '0;
            weight       <= '0;
            weight_valid <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            weight_valid <= '0;
            busy         <= (state_nx != ST_IDLE);
            done         <= (state == ST_DONE);
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        count_q  <= start_count;
                        core_idx <= '0;
                        word_cnt <= '0;
                    end
                end
                ST_WEIGHT: begin
                    if (hs) begin
                        weight       <= s_data[WEIGHT_WIDTH-1:0];
                        weight_valid <= core_onehot;
                        if (last_word) begin
                            word_cnt <= '0;
`ifndef PE_WEIGHT_LOADER_BIAS_EN
                            if (!last_core) begin
                                core_idx <= core_idx + IDX_W'(1);
                            end
`endif
                        end else begin
                            word_cnt <= word_cnt + WCNT_W'(1);
                        end
                    end
                end
`ifdef PE_WEIGHT_LOADER_BIAS_EN
                ST_BIAS: begin
                    if (hs && !last_core) begin
                        core_idx <= core_idx + IDX_W'(1);
                        word_cnt <= '0;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

`ifdef PE_WEIGHT_LOADER_BIAS_EN
    // Bias word capture and one-hot load strobe for the addressed core.
    always_ff @(posedge DSP_clk or negedge rst_n) begin
        if (!rst_n) begin
            bias       <= '0;
            bias_valid <= '0;
        end else begin
            bias_valid <= '0;
            if (state == ST_BIAS && hs) begin
                bias       <= s_data;
                bias_valid <= core_onehot;
            end
        end
    end
`else
    logic unused_data_hi;
    assign unused_data_hi = ^s_data[BIAS_WIDTH-1:WEIGHT_WIDTH];
    assign bias           = '0;
    assign bias_valid     = '0;
`endif

endmodule
